// File: rtl/arbiter_pkg.sv
// Shared helpers and reset constants for the arbiter family.
package arbiter_pkg;

  localparam int unsigned IDX_RST = 0;
  localparam int unsigned PTR_RST = 0;

  // Index width that stays at least one bit for single-channel instances.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/priority_encoder.sv
// Fixed-priority encoder: the lowest set index wins, combinational only.
module priority_encoder
  import arbiter_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             none
);

  // Scan from the top down so the lowest requester overwrites the others.
  always_comb begin
    idx  = '0;
    none = 1'b1;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx  = IDX_W'(i);
        none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rr_priority_arbiter.sv
// Round-robin arbiter with a rotating priority pointer and an optional grant lock.
module rr_priority_arbiter
  import arbiter_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter bit          LOCK  = 1'b0,
  parameter int unsigned IDX_W = idx_width(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             none
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic             none_q, none_d;

  logic [N-1:0]     mask_c;
  logic [N-1:0]     masked_req_c;
  logic [IDX_W-1:0] idx_m_c, idx_u_c, win_c, ptr_nxt_c;
  logic             none_m_c, none_u_c;
  logic             locked_c;

  // Channels at or above the pointer keep their priority this round.
  always_comb begin
    mask_c = '0;
    for (int i = 0; i < N; i++) begin
      mask_c[i] = (i >= int'(ptr_q));
    end
  end

  assign masked_req_c = req & mask_c;

  priority_encoder #(.N(N), .IDX_W(IDX_W)) u_pe_masked (
    .req  (masked_req_c),
    .idx  (idx_m_c),
    .none (none_m_c)
  );

  priority_encoder #(.N(N), .IDX_W(IDX_W)) u_pe_unmasked (
    .req  (req),
    .idx  (idx_u_c),
    .none (none_u_c)
  );

  assign win_c     = none_m_c ? idx_u_c : idx_m_c;
  assign ptr_nxt_c = (win_c == IDX_W'(N - 1)) ? '0 : win_c + 1'b1;
  // gnt_q is one-hot of gnt_idx_q whenever valid, so this is req[gnt_idx] gated by valid.
  assign locked_c  = LOCK && (|(req & gnt_q));

  always_comb begin
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    none_d      = none_q;
    if (en && !locked_c) begin
      if (!none_u_c) begin
        for (int i = 0; i < N; i++) begin
          gnt_d[i] = (IDX_W'(i) == win_c);
        end
        gnt_idx_d   = win_c;
        gnt_valid_d = 1'b1;
        none_d      = 1'b0;
        ptr_d       = ptr_nxt_c;
      end else begin
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
        none_d      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= IDX_W'(PTR_RST);
      gnt_q       <= '0;
      gnt_idx_q   <= IDX_W'(IDX_RST);
      gnt_valid_q <= 1'b0;
      none_q      <= 1'b1;
    end else begin
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      none_q      <= none_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;
  assign none      = none_q;

endmodule
